// File: rtl/pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_pkg
// Purpose  : Shared pipeline encodings (Op field, hazard FSM states, widths)
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W = 5;

    localparam logic [2:0] OP_NONE   = 3'b000;
    localparam logic [2:0] OP_ALU    = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_STORE  = 3'b011;
    localparam logic [2:0] OP_BRANCH = 3'b100;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        MISS_DONE = 2'd3
    } miss_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl_if
// Purpose  : Data-memory miss handshake between pipeline and hazard control
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

    logic mem_req_i;   // MEM-stage access present
    logic mem_hit_i;   // cache hit for that access
    logic mem_ack_i;   // fill complete
    logic mem_req_o;   // one-cycle fill request

    // Pipeline/memory side drives the access status and sees the request
    modport master (output mem_req_i, output mem_hit_i, output mem_ack_i,
                    input  mem_req_o);

    // Hazard controller consumes the status and issues the request
    modport slave  (input  mem_req_i, input  mem_hit_i, input  mem_ack_i,
                    output mem_req_o);

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hazard_detect
// Purpose  : Combinational load-use comparator between ID and EX stages
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
(
    input  wire logic [REG_W-1:0] i_id_rs,
    input  wire logic [REG_W-1:0] i_id_rt,
    input  wire logic             i_id_valid,
    input  wire logic [REG_W-1:0] i_ex_rsd,
    input  wire logic [2:0]       i_ex_op,
    input  wire logic             i_ex_valid,
    output logic                  o_hz
);

    // A load writing r0 never creates a dependency, so it is excluded
    always_comb begin
        o_hz = i_ex_valid && (i_ex_op == OP_LOAD) && (i_ex_rsd != '0) &&
               i_id_valid && ((i_ex_rsd == i_id_rs) || (i_ex_rsd == i_id_rt));
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipe_hazard_ctrl
// Purpose  : Pipeline stall/flush sequencer: data-miss FSM, load-use bubble,
//            taken-branch flush, stall performance counter
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 200,
    parameter int CNT_W   = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    pipe_hazard_ctrl_if.slave     mem_if,
    input  wire logic [REG_W-1:0] id_rs_i,
    input  wire logic [REG_W-1:0] id_rt_i,
    input  wire logic             id_valid_i,
    input  wire logic [REG_W-1:0] ex_rsd_i,
    input  wire logic [2:0]       ex_op_i,
    input  wire logic             ex_valid_i,
    input  wire logic             branch_taken_i,
    output logic                  all_stall_o,
    output logic                  pc_stall_o,
    output logic                  ifid_stall_o,
    output logic                  ifid_flush_o,
    output logic                  idex_bubble_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // Last wait-counter value before the miss is abandoned
    localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

    miss_state_t      r_state;
    miss_state_t      w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_all_stall;
    logic             w_mem_req;
    logic             w_to_set;
    logic             w_hz;

    hazard_detect u_hazard_detect (
        .i_id_rs    (id_rs_i),
        .i_id_rt    (id_rt_i),
        .i_id_valid (id_valid_i),
        .i_ex_rsd   (ex_rsd_i),
        .i_ex_op    (ex_op_i),
        .i_ex_valid (ex_valid_i),
        .o_hz       (w_hz)
    );

    // Miss FSM state register and wait counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == MISS_REQ)
                r_wait_cnt <= '0;
            else if (r_state == MISS_WAIT)
                r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Next state and stall/request decode; stall starts in the detect cycle
    always_comb begin
        w_state_nxt = r_state;
        w_all_stall = 1'b0;
        w_mem_req   = 1'b0;
        w_to_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_if.mem_req_i && !mem_if.mem_hit_i) begin
                    w_all_stall = 1'b1;
                    w_state_nxt = MISS_REQ;
                end
            end
            MISS_REQ: begin
                w_all_stall = 1'b1;
                w_mem_req   = 1'b1;
                w_state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                w_all_stall = 1'b1;
                if (mem_if.mem_ack_i) begin
                    w_state_nxt = MISS_DONE;
                end else if (r_wait_cnt == c_wait_last) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = MISS_DONE;
                end
            end
            MISS_DONE: begin
                // One free cycle so buffers advance past the missed access
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Sticky timeout flag and saturating stall-cycle counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_to_set)
                r_timeout <= 1'b1;
            if (w_all_stall && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // Output priority (miss stall > load-use > flush), all gated by reset
    always_comb begin
        all_stall_o      = w_all_stall & ~rst_i;
        mem_if.mem_req_o = w_mem_req & ~rst_i;
        pc_stall_o       = w_hz & ~w_all_stall & ~rst_i;
        ifid_stall_o     = w_hz & ~w_all_stall & ~rst_i;
        idex_bubble_o    = w_hz & ~w_all_stall & ~rst_i;
        ifid_flush_o     = branch_taken_i & ~w_hz & ~w_all_stall & ~rst_i;
        busy_o           = (r_state != IDLE) & ~rst_i;
        timeout_o        = r_timeout & ~rst_i;
        stall_cnt_o      = rst_i ? '0 : r_stall_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int TIMEOUT = 5;
    localparam int CNT_W   = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       id_rs_i, id_rt_i, ex_rsd_i;
    logic             id_valid_i, ex_valid_i, branch_taken_i;
    logic [2:0]       ex_op_i;
    logic             all_stall_o, pc_stall_o, ifid_stall_o, ifid_flush_o;
    logic             idex_bubble_o, busy_o, timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl_if mem_if ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .mem_if         (mem_if.slave),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_valid_i     (id_valid_i),
        .ex_rsd_i       (ex_rsd_i),
        .ex_op_i        (ex_op_i),
        .ex_valid_i     (ex_valid_i),
        .branch_taken_i (branch_taken_i),
        .all_stall_o    (all_stall_o),
        .pc_stall_o     (pc_stall_o),
        .ifid_stall_o   (ifid_stall_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .busy_o         (busy_o),
        .timeout_o      (timeout_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       mem_req, mem_hit;
        logic       ex_valid;
        logic [2:0] ex_op;
        logic [4:0] ex_rsd;
        logic       id_valid;
        logic [4:0] id_rs, id_rt;
        logic       branch;
        logic       e_pc_stall, e_ifid_stall, e_flush, e_bubble;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_if.mem_req_i = 0; mem_if.mem_hit_i = 0; mem_if.mem_ack_i = 0;
        ex_valid_i = 0; ex_op_i = OP_NONE; ex_rsd_i = 0;
        id_valid_i = 0; id_rs_i = 0; id_rt_i = 0; branch_taken_i = 0;
    endtask

    // Start a miss from IDLE; returns just after the edge entering MISS_WAIT
    task automatic start_miss();
        mem_if.mem_req_i = 1; mem_if.mem_hit_i = 0;
        next_cycle();             // now MISS_REQ
        mem_if.mem_req_i = 0;
        next_cycle();             // now first MISS_WAIT
    endtask

    initial begin
        logic [CNT_W-1:0] cnt0;
        int stalls, reqs;

        //           mreq hit exv op        rsd idv rs  rt  br   pc ifs fl bub
        vecs[0]  = '{0, 0, 1, OP_LOAD,   7, 1,  1,  7,  0,   1, 1, 0, 1};
        vecs[1]  = '{0, 0, 1, OP_LOAD,   7, 1,  7,  2,  0,   1, 1, 0, 1};
        vecs[2]  = '{0, 0, 1, OP_LOAD,   0, 1,  0,  0,  0,   0, 0, 0, 0};
        vecs[3]  = '{0, 0, 1, OP_ALU,    7, 1,  1,  7,  0,   0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, OP_LOAD,   7, 1,  1,  7,  0,   0, 0, 0, 0};
        vecs[5]  = '{0, 0, 1, OP_LOAD,   7, 0,  1,  7,  0,   0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, OP_LOAD,   7, 1,  3,  4,  0,   0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, OP_NONE,   0, 0,  0,  0,  1,   0, 0, 1, 0};
        vecs[8]  = '{0, 0, 1, OP_LOAD,   7, 1,  1,  7,  1,   1, 1, 0, 1};
        vecs[9]  = '{0, 0, 1, OP_LOAD,   0, 1,  0,  0,  1,   0, 0, 1, 0};
        vecs[10] = '{0, 0, 1, OP_STORE, 7, 1,  1,  7,  1,   0, 0, 1, 0};
        vecs[11] = '{1, 1, 0, OP_NONE,   0, 0,  0,  0,  0,   0, 0, 0, 0};
        vecs[12] = '{1, 1, 1, OP_LOAD,  31, 1, 31,  0,  1,   1, 1, 0, 1};

        // Reset: outputs gated low even with a miss presented
        idle_inputs();
        rst_i = 1;
        mem_if.mem_req_i = 1;
        ex_valid_i = 1; ex_op_i = OP_LOAD; ex_rsd_i = 7; id_valid_i = 1; id_rt_i = 7;
        branch_taken_i = 1;
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        chk("rst_outputs", {all_stall_o, pc_stall_o, ifid_stall_o, ifid_flush_o,
                            idex_bubble_o, busy_o, timeout_o, mem_if.mem_req_o}, 0);
        chk("rst_cnt", 32'(stall_cnt_o), 0);
        next_cycle();
        idle_inputs();
        rst_i = 0;
        next_cycle();

        // Combinational hazard/flush vectors in IDLE (hits never stall)
        for (int i = 0; i < 13; i++) begin
            mem_if.mem_req_i = vecs[i].mem_req; mem_if.mem_hit_i = vecs[i].mem_hit;
            ex_valid_i = vecs[i].ex_valid; ex_op_i = vecs[i].ex_op; ex_rsd_i = vecs[i].ex_rsd;
            id_valid_i = vecs[i].id_valid; id_rs_i = vecs[i].id_rs; id_rt_i = vecs[i].id_rt;
            branch_taken_i = vecs[i].branch;
            @(negedge clk_i);
            chk($sformatf("vec%0d", i),
                {pc_stall_o, ifid_stall_o, ifid_flush_o, idex_bubble_o,
                 all_stall_o, mem_if.mem_req_o, busy_o},
                {vecs[i].e_pc_stall, vecs[i].e_ifid_stall, vecs[i].e_flush,
                 vecs[i].e_bubble, 3'b000});
            next_cycle();
        end
        idle_inputs();
        chk("hit_cnt", 32'(stall_cnt_o), 0);

        // Miss, ack in the 4th MISS_WAIT cycle: 6 stall cycles, one request pulse
        stalls = 0; reqs = 0;
        mem_if.mem_req_i = 1; mem_if.mem_hit_i = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) mem_if.mem_req_i = 0;
            mem_if.mem_ack_i = (c == 5);
            @(negedge clk_i);
            stalls += int'(all_stall_o);
            reqs   += int'(mem_if.mem_req_o);
            if (c == 1) chk("req_in_miss_req", 32'(mem_if.mem_req_o), 1);
            next_cycle();
        end
        mem_if.mem_ack_i = 0;
        chk("miss_stalls", stalls, 6);
        chk("miss_req_pulses", reqs, 1);
        // MISS_DONE: no stall, re-presented miss is ignored
        mem_if.mem_req_i = 1; mem_if.mem_hit_i = 0;
        @(negedge clk_i);
        chk("done_no_stall", {all_stall_o, busy_o}, 2'b01);
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        chk("done_to_idle", {all_stall_o, busy_o, mem_if.mem_req_o}, 0);
        chk("miss_cnt", 32'(stall_cnt_o), 6);
        next_cycle();

        // Ack in the last allowed MISS_WAIT cycle: no timeout
        start_miss();
        for (int c = 0; c < TIMEOUT; c++) begin
            mem_if.mem_ack_i = (c == TIMEOUT - 1);
            next_cycle();
        end
        mem_if.mem_ack_i = 0;
        @(negedge clk_i);
        chk("ack_last_no_to", {timeout_o, all_stall_o, busy_o}, 3'b001);
        next_cycle();
        next_cycle();

        // Never ack: timeout after TIMEOUT waits, sticky, return to IDLE
        cnt0 = stall_cnt_o;
        start_miss();
        for (int c = 0; c < TIMEOUT; c++) begin
            if (c == 1) begin
                // Branch and load-use during a miss are suppressed
                branch_taken_i = 1; ex_valid_i = 1; ex_op_i = OP_LOAD; ex_rsd_i = 3;
                id_valid_i = 1; id_rs_i = 3;
                @(negedge clk_i);
                chk("miss_suppress", {ifid_flush_o, pc_stall_o, ifid_stall_o,
                                      idex_bubble_o, all_stall_o}, 5'b00001);
            end
            if (c == 2) idle_inputs();
            next_cycle();
        end
        @(negedge clk_i);
        chk("to_set", {timeout_o, all_stall_o, busy_o}, 3'b101);
        chk("to_stall_cnt", 32'(stall_cnt_o - cnt0), 32'(TIMEOUT + 2));
        next_cycle();
        next_cycle();
        @(negedge clk_i);
        chk("to_sticky", {timeout_o, busy_o}, 2'b10);
        next_cycle();

        // Reset mid-miss: everything clears, late ack ignored, no re-request
        start_miss();
        next_cycle();
        rst_i = 1;
        @(negedge clk_i);
        chk("rst_mid_gate", {all_stall_o, busy_o, timeout_o}, 0);
        next_cycle();
        rst_i = 0;
        mem_if.mem_ack_i = 1;
        reqs = 0; stalls = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            reqs   += int'(mem_if.mem_req_o);
            stalls += int'(all_stall_o) + int'(busy_o);
            next_cycle();
        end
        mem_if.mem_ack_i = 0;
        chk("rst_mid_quiet", {reqs[7:0], stalls[7:0]}, 0);
        chk("rst_mid_state", {32'(stall_cnt_o), 31'd0, timeout_o}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
